// File: rtl/iterative_normalizer_pkg.sv
// Shared types and helpers for the iterative normalizer: FSM state encoding
// and a width-generic bit reversal used to map right-normalization onto left.
package iterative_normalizer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_W   = 64;
    localparam int MAX_IDX = $clog2(MAX_W);

    // Reverses the low w bits of x; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] reverse_bits(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[MAX_IDX'(i)] = x[MAX_IDX'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iterative_normalizer_norm_step.sv
// One binary-search step: tests whether the top 2**k bits are all zero and
// provides the word shifted left by 2**k for the caller to take if so.
module iterative_normalizer_norm_step #(
    parameter int N  = 3,
    parameter int KW = 2
) (
    input  logic [2**N-1:0] word_i,
    input  logic [KW-1:0]   k_i,
    output logic [2**N-1:0] shifted_o,
    output logic            fire_o
);
    localparam int W = 2**N;

    int unsigned span;

    always_comb begin
        span      = 32'd1 << k_i;
        fire_o    = ((word_i >> (W - span)) == '0);
        shifted_o = word_i << span;
    end

endmodule

// File: rtl/iterative_normalizer.sv
// Multi-cycle leading/trailing-zero normalizer: N-step binary search, one step
// per clock, with valid/ready handshakes on both sides.
module iterative_normalizer
    import iterative_normalizer_pkg::*;
#(
    parameter int N = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] num,
    input  logic            select,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**N-1:0] norm,
    output logic [N-1:0]    count,
    output logic            zero
);
    localparam int W  = 2**N;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [N-1:0]    acc_q;
    logic [W-1:0]    word_q;
    logic            sel_q;
    logic            out_valid_q;
    logic [W-1:0]    norm_q;
    logic [N-1:0]    count_q;
    logic            zero_q;

    logic [W-1:0]    step_shifted;
    logic            step_fire;
    logic [W-1:0]    word_d;
    logic [N-1:0]    acc_d;
    logic [N-1:0]    step_inc;
    logic [W-1:0]    capture_d;
    logic [W-1:0]    norm_d;

    iterative_normalizer_norm_step #(
        .N  (N),
        .KW (KW)
    ) u_step (
        .word_i    (word_q),
        .k_i       (k_q),
        .shifted_o (step_shifted),
        .fire_o    (step_fire)
    );

    // Right mode works on the reversed word so a single left-shifting datapath serves both.
    always_comb begin
        step_inc       = '0;
        step_inc[k_q]  = 1'b1;
        word_d         = step_fire ? step_shifted : word_q;
        acc_d          = step_fire ? (acc_q + step_inc) : acc_q;
        capture_d      = select ? W'(reverse_bits(MAX_W'(num), W)) : num;
        norm_d         = sel_q ? W'(reverse_bits(MAX_W'(word_d), W)) : word_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            norm_q      <= '0;
            count_q     <= '0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        word_q  <= capture_d;
                        acc_q   <= '0;
                        k_q     <= KW'(N - 1);
                        sel_q   <= select;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    word_q <= word_d;
                    acc_q  <= acc_d;
                    if (k_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        norm_q      <= norm_d;
                        count_q     <= acc_d;
                        // Shifting only discards zeros, so the final word is zero iff the operand was.
                        zero_q      <= (word_d == '0);
                    end else begin
                        k_q <= k_q - KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign norm      = norm_q;
    assign count     = count_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_iterative_normalizer.sv
// Self-checking bench for iterative_normalizer (N=3): directed corner cases,
// backpressure, mid-run reset and randomized operands against a zero-count model.
module tb_iterative_normalizer;
    localparam int N = 3;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  num;
    logic          select;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  norm;
    logic [N-1:0]  count;
    logic          zero;

    int checks = 0;
    int errors = 0;

    iterative_normalizer #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .norm      (norm),
        .count     (count),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: count zeros from the chosen end, then shift them out.
    function automatic void model(input logic [W-1:0] v, input logic sel,
                                  output logic [W-1:0] en, output logic [N-1:0] ec,
                                  output logic ez);
        int z;
        bit found;
        z = 0;
        found = 0;
        if (v == '0) begin
            en = '0;
            ec = N'(W - 1);
            ez = 1'b1;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (!found) begin
                    if ((sel ? v[i] : v[W-1-i]) == 1'b1) found = 1;
                    else z++;
                end
            end
            en = sel ? (v >> z) : (v << z);
            ec = N'(z);
            ez = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with out_ready held high; entered and left at #1 after an edge.
    task automatic do_txn(input logic [W-1:0] v, input logic sel);
        logic [W-1:0] en;
        logic [N-1:0] ec;
        logic         ez;
        int           lat;
        model(v, sel, en, ec, ez);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        num       = v;
        select    = sel;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        num      = W'($urandom);
        select   = 1'($urandom);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(N));
        check("norm", 32'(norm), 32'(en));
        check("count", 32'(count), 32'(ec));
        check("zero", 32'(zero), 32'(ez));
        $display("txn num=%02h sel=%0d -> norm=%02h count=%0d zero=%0d lat=%0d",
                 v, sel, norm, count, zero, lat);
        tick();
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] en;
        logic [N-1:0] ec;
        logic         ez;
        int           lat;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        num       = '0;
        select    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_norm", 32'(norm), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        reset_n = 1'b1;
        tick();

        do_txn(8'b0001_0110, 1'b0);
        do_txn(8'b0010_1000, 1'b1);
        do_txn(8'h00, 1'b0);
        do_txn(8'h00, 1'b1);
        do_txn(8'b1000_0000, 1'b0);
        do_txn(8'h01, 1'b1);
        do_txn(8'h01, 1'b0);
        do_txn(8'h80, 1'b1);

        // Backpressure: result must hold steady and new operands be ignored.
        v = 8'b0100_1100;
        model(v, 1'b0, en, ec, ez);
        in_valid  = 1'b1;
        num       = v;
        select    = 1'b0;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(N));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            num      = W'($urandom);
            select   = 1'($urandom);
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_norm", 32'(norm), 32'(en));
            check("bp_count", 32'(count), 32'(ec));
            check("bp_zero", 32'(zero), 32'(ez));
        end
        $display("txn backpressure num=%02h -> norm=%02h count=%0d zero=%0d", v, norm, count, zero);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_hs_out_valid", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_no_capture_valid", 32'(out_valid), 32'd0);
        check("bp_no_capture_ready", 32'(in_ready), 32'd1);
        check("bp_hold_norm", 32'(norm), 32'(en));
        check("bp_hold_count", 32'(count), 32'(ec));

        // Reset during the second search step aborts the transaction.
        in_valid = 1'b1;
        num      = 8'h30;
        select   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_norm", 32'(norm), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        $display("txn reset mid-run -> out_valid=%0d in_ready=%0d", out_valid, in_ready);
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        do_txn(8'h30, 1'b1);

        for (int t = 0; t < 40; t++) begin
            v = W'($urandom);
            if ($urandom_range(0, 1) == 1) v = v >> $urandom_range(0, 7);
            else                            v = v << $urandom_range(0, 7);
            do_txn(v, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

endmodule
